// File: rtl/mu0_sequencer.sv
// mu0_sequencer: control sequencer for the MU0 accumulator machine.
//
// One FETCH cycle and one EXEC cycle per instruction when memory answers at
// once. Memory-using states wait on mem_ack and hold every output steady
// while they wait.
//
// Optional build macro:
//   MU0_ILLEGAL_TRAP_EN - opcodes 8..15 trap into HALT and raise illegal.
//                         If it is undefined they are one-cycle no-ops and
//                         illegal is tied low.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | one cycle after reset: clear PC and ACC through the ALU zero path
// FETCH | read M[PC] into IR, PC <= PC + 1 on mem_ack
// EXEC  | decode and execute opcode; memory ops wait for mem_ack
// HALT  | STP or illegal trap; everything idle until reset
//
// The decode is combinational on state, opcode and the mem_ack/flag inputs.
// It cannot be registered for two reasons. The opcode only becomes valid in
// the cycle after IR is loaded. The ir_ce, pc_ce and acc_ce strobes must
// follow mem_ack within the same cycle. halted and illegal are registered
// status flags. The state register is cleared asynchronously, so reset forces
// the INIT output values straight away.

module mu0_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       acc_z,
  input  logic       acc_n,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_wr,
  output logic       asel,
  output logic       bsel,
  output logic [2:0] alufs,
  output logic       pc_sel,
  output logic       pc_ce,
  output logic       ir_ce,
  output logic       acc_ce,
  output logic       acc_oe,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_B    = 3'd3;
  localparam logic [2:0] ALU_INCB = 3'd4;

  state_t state;
  state_t state_nx;
  logic   halted_q;
`ifdef MU0_ILLEGAL_TRAP_EN
  logic   illegal_q;
  logic   trap_take;
`endif

  // Decode the control word and the next state from state, opcode and inputs.
  always_comb begin
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    alufs    = ALU_ZERO;
    pc_sel   = 1'b0;
    pc_ce    = 1'b0;
    ir_ce    = 1'b0;
    acc_ce   = 1'b0;
    acc_oe   = 1'b0;
    state_nx = state;
`ifdef MU0_ILLEGAL_TRAP_EN
    trap_take = 1'b0;
`endif
    case (state)
      INIT: begin
        // The ALU zero output is loaded into both PC and ACC.
        alufs    = ALU_ZERO;
        pc_sel   = 1'b0;
        pc_ce    = 1'b1;
        acc_ce   = 1'b1;
        state_nx = FETCH;
      end

      FETCH: begin
        // PC is the address; the ALU computes PC + 1 through the B input.
        mem_req = 1'b1;
        asel    = 1'b0;
        bsel    = 1'b1;
        alufs   = ALU_INCB;
        if (mem_ack) begin
          ir_ce    = 1'b1;
          pc_ce    = 1'b1;
          state_nx = EXEC;
        end
      end

      EXEC: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            mem_req = 1'b1;
            asel    = 1'b1;
            bsel    = 1'b0;
            if (opcode == OP_LDA)      alufs = ALU_B;
            else if (opcode == OP_ADD) alufs = ALU_ADD;
            else                       alufs = ALU_SUB;
            if (mem_ack) begin
              acc_ce   = 1'b1;
              state_nx = FETCH;
            end
          end

          OP_STA: begin
            // ACC drives the write-data bus; the ALU is idle.
            mem_req = 1'b1;
            mem_wr  = 1'b1;
            asel    = 1'b1;
            acc_oe  = 1'b1;
            if (mem_ack) state_nx = FETCH;
          end

          OP_JMP: begin
            pc_sel   = 1'b1;
            pc_ce    = 1'b1;
            state_nx = FETCH;
          end

          OP_JGE: begin
            if (!acc_n) begin
              pc_sel = 1'b1;
              pc_ce  = 1'b1;
            end
            state_nx = FETCH;
          end

          OP_JNE: begin
            if (!acc_z) begin
              pc_sel = 1'b1;
              pc_ce  = 1'b1;
            end
            state_nx = FETCH;
          end

          OP_STP: begin
            state_nx = HALT;
          end

          default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
            trap_take = 1'b1;
            state_nx  = HALT;
`else
            state_nx  = FETCH;
`endif
          end
        endcase
      end

      HALT: begin
        state_nx = HALT;
      end

      default: begin
        state_nx = INIT;
      end
    endcase
  end

  // State register and sticky status flags; reset returns to INIT at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      halted_q  <= 1'b0;
`ifdef MU0_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      halted_q  <= (state_nx == HALT);
`ifdef MU0_ILLEGAL_TRAP_EN
      illegal_q <= illegal_q | trap_take;
`endif
    end
  end

  assign halted = halted_q;
`ifdef MU0_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: table-driven check of the MU0 sequencer control word,
// plus hand-written reset sequences.
// Control word layout: {mem_req, mem_wr, asel, bsel, alufs[2:0], pc_sel,
//                       pc_ce, ir_ce, acc_ce, acc_oe, halted, illegal}

module tb_mu0_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       acc_z;
  logic       acc_n;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_wr;
  logic       asel;
  logic       bsel;
  logic [2:0] alufs;
  logic       pc_sel;
  logic       pc_ce;
  logic       ir_ce;
  logic       acc_ce;
  logic       acc_oe;
  logic       halted;
  logic       illegal;

  int total;
  int bad;

  mu0_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .acc_z   (acc_z),
    .acc_n   (acc_n),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .mem_wr  (mem_wr),
    .asel    (asel),
    .bsel    (bsel),
    .alufs   (alufs),
    .pc_sel  (pc_sel),
    .pc_ce   (pc_ce),
    .ir_ce   (ir_ce),
    .acc_ce  (acc_ce),
    .acc_oe  (acc_oe),
    .halted  (halted),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] outs;
  assign outs = {mem_req, mem_wr, asel, bsel, alufs, pc_sel,
                 pc_ce, ir_ce, acc_ce, acc_oe, halted, illegal};

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        n;
    logic        ack;
    logic [13:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [13:0] mk(input logic mr, input logic mw,
                                     input logic as, input logic bs,
                                     input logic [2:0] af, input logic ps,
                                     input logic pce, input logic ice,
                                     input logic ace, input logic aoe,
                                     input logic h, input logic il);
    return {mr, mw, as, bs, af, ps, pce, ice, ace, aoe, h, il};
  endfunction

  logic [13:0] e_init, e_fack, e_fwait, e_lda, e_add, e_sub, e_subw;
  logic [13:0] e_sta, e_staw, e_jmp, e_none, e_halt, e_trap;

  task automatic add(input logic [3:0] op, input logic z, input logic n,
                     input logic ack, input logic [13:0] exp);
    vec_t v;
    v.op = op; v.z = z; v.n = n; v.ack = ack; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [13:0] act,
                     input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  // Each vector covers one cycle: drive at negedge, compare 1 ns later.
  task automatic run_vecs(input int from, input int to);
    for (int i = from; i < to; i++) begin
      opcode  = vq[i].op;
      acc_z   = vq[i].z;
      acc_n   = vq[i].n;
      mem_ack = vq[i].ack;
      #1;
      chk($sformatf("vec%0d", i), outs, vq[i].exp);
      @(negedge clk);
    end
  endtask

  int p1_end, p2_end, p3_end;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    opcode = 4'd0; acc_z = 1'b0; acc_n = 1'b0; mem_ack = 1'b0;

    e_init  = mk(0,0,0,0,3'd0,0,1,0,1,0,0,0);
    e_fack  = mk(1,0,0,1,3'd4,0,1,1,0,0,0,0);
    e_fwait = mk(1,0,0,1,3'd4,0,0,0,0,0,0,0);
    e_lda   = mk(1,0,1,0,3'd3,0,0,0,1,0,0,0);
    e_add   = mk(1,0,1,0,3'd1,0,0,0,1,0,0,0);
    e_sub   = mk(1,0,1,0,3'd2,0,0,0,1,0,0,0);
    e_subw  = mk(1,0,1,0,3'd2,0,0,0,0,0,0,0);
    e_sta   = mk(1,1,1,0,3'd0,0,0,0,0,1,0,0);
    e_staw  = e_sta;
    e_jmp   = mk(0,0,0,0,3'd0,1,1,0,0,0,0,0);
    e_none  = mk(0,0,0,0,3'd0,0,0,0,0,0,0,0);
    e_halt  = mk(0,0,0,0,3'd0,0,0,0,0,0,1,0);
    e_trap  = mk(0,0,0,0,3'd0,0,0,0,0,0,1,1);

    // Part 1: LDA, ADD, STA, STP with zero-wait memory, then HALT.
    add(4'd0, 0, 0, 1, e_init);   // the ack is ignored in INIT
    add(4'd0, 0, 0, 1, e_fack);
    add(4'd0, 0, 0, 1, e_lda);
    add(4'd0, 0, 0, 1, e_fack);
    add(4'd2, 0, 0, 1, e_add);
    add(4'd2, 0, 0, 1, e_fack);
    add(4'd1, 0, 0, 1, e_sta);
    add(4'd1, 0, 0, 1, e_fack);
    add(4'd7, 0, 0, 1, e_none);   // STP: no request, so the ack is ignored
    add(4'd4, 0, 0, 1, e_halt);
    add(4'd0, 0, 0, 0, e_halt);
    add(4'd2, 0, 0, 1, e_halt);
    p1_end = vq.size();

    // Part 2: FETCH waits, a SUB with a wait state, and jumps.
    add(4'd0, 0, 0, 0, e_init);
    add(4'd0, 0, 0, 0, e_fwait);
    add(4'd0, 0, 0, 0, e_fwait);
    add(4'd0, 0, 0, 0, e_fwait);
    add(4'd0, 0, 0, 1, e_fack);
    add(4'd3, 0, 0, 0, e_subw);
    add(4'd3, 0, 0, 1, e_sub);
    add(4'd3, 0, 0, 1, e_fack);
    add(4'd4, 0, 0, 0, e_jmp);
    add(4'd4, 0, 0, 1, e_fack);
    add(4'd5, 0, 1, 0, e_none);   // JGE not taken
    add(4'd5, 0, 0, 1, e_fack);
    add(4'd5, 1, 0, 0, e_jmp);    // JGE taken
    add(4'd5, 0, 0, 1, e_fack);
    add(4'd6, 1, 0, 0, e_none);   // JNE not taken
    add(4'd6, 0, 0, 1, e_fack);
    add(4'd6, 0, 1, 0, e_jmp);    // JNE taken
    add(4'd6, 0, 0, 1, e_fack);
    p2_end = vq.size();

    // Part 3: opcode 9 after a reset.
    add(4'd0, 0, 0, 0, e_init);
    add(4'd0, 0, 0, 1, e_fack);
    add(4'd9, 0, 0, 0, e_none);
`ifdef MU0_ILLEGAL_TRAP_EN
    add(4'd9, 0, 0, 1, e_trap);
    add(4'd0, 0, 0, 1, e_trap);
    add(4'd1, 0, 0, 0, e_trap);
`else
    add(4'd9, 0, 0, 1, e_fack);
    add(4'd7, 0, 0, 1, e_none);
    add(4'd0, 0, 0, 1, e_halt);
`endif
    p3_end = vq.size();

    repeat (3) @(negedge clk);
    chk("reset_out", outs, e_init);
    reset = 1'b0;
    run_vecs(0, p1_end);

    // Reset from HALT.
    reset = 1'b1;
    #1;
    chk("halt_reset", outs, e_init);
    @(negedge clk);
    reset = 1'b0;
    run_vecs(p1_end, p2_end);

    // STA waiting for memory, then reset asserted in mid-transfer.
    opcode = 4'd1; mem_ack = 1'b0; acc_z = 1'b0; acc_n = 1'b0;
    #1;
    chk("sta_wait", outs, e_staw);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_sta_reset", outs, e_init);
    @(negedge clk);
    #1;
    chk("reset_held", outs, e_init);
    @(negedge clk);
    reset = 1'b0;
    run_vecs(p2_end, p3_end);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mu0_sequencer.md
MU0_SEQUENCER -- requirements
Module: mu0_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  4  IR[15:12], valid from the cycle after IR load
- acc_z  input  1  accumulator == 0
- acc_n  input  1  accumulator bit 15
- mem_ack  input  1  memory transfer complete this cycle
- mem_req  output  1  memory access request
- mem_wr  output  1  1 = write, 0 = read; valid only with mem_req
- asel  output  1  address source: 0 = PC, 1 = IR[11:0]
- bsel  output  1  ALU B source: 0 = memory read data, 1 = PC
- alufs  output  3  ALU function: 0 zero, 1 A+B, 2 A-B, 3 B, 4 B+1
- pc_sel  output  1  PC load source: 0 = ALU out, 1 = IR[11:0]
- pc_ce, ir_ce, acc_ce  output  1 each  register load enables
- acc_oe  output  1  drive accumulator onto write-data bus
- halted  output  1  STP executed
- illegal  output  1  illegal opcode trap taken

Function
REQ-002 The FSM SHALL have states INIT, FETCH, EXEC and HALT, held in a registered state variable.
REQ-003 INIT SHALL last one cycle: alufs=0, pc_sel=0, pc_ce=1, acc_ce=1 (clears PC and ACC); the next state SHALL be FETCH.
REQ-004 FETCH SHALL drive mem_req=1, mem_wr=0, asel=0, bsel=1 and alufs=4.
REQ-005 In FETCH, ir_ce and pc_ce SHALL be asserted combinationally only in the cycle mem_ack=1; the next state SHALL then be EXEC.
REQ-006 While mem_ack=0 in FETCH or in a memory EXEC, the state and all outputs SHALL be held unchanged.
REQ-007 EXEC opcode 0 (LDA) SHALL drive mem_req=1, asel=1, bsel=0, alufs=3, with acc_ce=1 in the mem_ack cycle.
REQ-008 EXEC opcode 1 (STA) SHALL drive mem_req=1, mem_wr=1, asel=1, acc_oe=1 and complete on mem_ack.
REQ-009 EXEC opcodes 2 (ADD) and 3 (SUB) SHALL behave as LDA but with alufs=1 and alufs=2 respectively.
REQ-010 EXEC opcode 4 (JMP) SHALL complete in one cycle with no memory access: pc_sel=1, pc_ce=1.
REQ-011 EXEC opcode 5 (JGE) SHALL behave as JMP when acc_n=0; otherwise it SHALL be a one-cycle no-op.
REQ-012 EXEC opcode 6 (JNE) SHALL behave as JMP when acc_z=0; otherwise it SHALL be a one-cycle no-op.
REQ-013 EXEC opcode 7 (STP) SHALL move to HALT; HALT SHALL drive halted=1 and all enables and mem_req at 0, and SHALL be left only by reset.
REQ-014 Every completed EXEC other than STP or a trap SHALL return to FETCH; with zero-wait memory each instruction SHALL take exactly 2 cycles.
REQ-015 Outputs not listed for a state SHALL be 0; alufs SHALL be 0 when no enable uses it.
REQ-016 mem_req SHALL remain asserted from the request cycle up to and including the mem_ack cycle, and SHALL never be asserted in INIT or HALT.
REQ-017 A mem_ack arriving while mem_req=0 SHALL be ignored.

Reset
REQ-018 Reset assertion SHALL immediately force state INIT and every output to its INIT value, including mid-transfer; halted=0 and illegal=0.
REQ-019 After reset deassertion, INIT SHALL execute for exactly one clock before FETCH.

Configuration
REQ-020 With MU0_ILLEGAL_TRAP_EN defined, EXEC opcodes 8-15 SHALL enter HALT with illegal=1 and halted=1.
REQ-021 Without MU0_ILLEGAL_TRAP_EN, opcodes 8-15 SHALL be one-cycle no-ops returning to FETCH, and illegal SHALL be tied to 0.

Verification
REQ-022 Zero-wait mem_ack, program LDA, ADD, STA, STP -> 8 cycles from the first FETCH, then halted=1; alufs sequence 4,3,4,1,4,x(STA),4 with acc_ce on LDA and ADD.
REQ-023 FETCH with mem_ack delayed 3 cycles -> mem_req high for 4 cycles, outputs stable throughout, ir_ce and pc_ce asserted only in the 4th cycle.
REQ-024 JGE with acc_n=1 -> pc_ce=0; with acc_n=0 -> pc_sel=1, pc_ce=1. JNE with acc_z=1 -> pc_ce=0.
REQ-025 Reset asserted mid-STA with mem_req=1 -> mem_req=0 and acc_ce=pc_ce=1 (INIT) before the next edge, then FETCH one cycle after release.
REQ-026 Opcode 9 -> with MU0_ILLEGAL_TRAP_EN: illegal=1, halted=1, no further mem_req; without it: return to FETCH after 1 cycle, illegal=0.
